// File: rtl/agg_oq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : agg_oq_arbiter
// Description : Packet-granular two-input AXI-Stream arbiter that merges the
//               bypass and aggregation streams. Optional macro
//               AGG_STRICT_PRIO_EN gives the aggregation input strict priority.
// Revision    : 1.0 - initial release
// ============================================================================
module agg_oq_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                            axis_aclk,
    input  logic                            axis_resetn,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_byp_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_byp_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_byp_tuser,
    input  logic                            s_axis_byp_tvalid,
    input  logic                            s_axis_byp_tlast,
    output logic                            s_axis_byp_tready,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_agg_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_agg_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_agg_tuser,
    input  logic                            s_axis_agg_tvalid,
    input  logic                            s_axis_agg_tlast,
    output logic                            s_axis_agg_tready,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,

    input  logic                            cnt_clear,
    output logic [CNT_WIDTH-1:0]            pkt_cnt_byp,
    output logic [CNT_WIDTH-1:0]            pkt_cnt_agg,
    output logic                            grant_busy
);

    localparam logic [0:0] c_state_idle = 1'b0;
    localparam logic [0:0] c_state_busy = 1'b1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]           r_state;
    logic                 r_sel;
    logic                 r_last_sel;
    logic [CNT_WIDTH-1:0] r_cnt_byp;
    logic [CNT_WIDTH-1:0] r_cnt_agg;

    logic w_busy;
    logic w_any_valid;
    logic w_grant;
    logic w_eop;

    assign w_busy      = (r_state == c_state_busy);
    assign w_any_valid = s_axis_byp_tvalid | s_axis_agg_tvalid;

`ifdef AGG_STRICT_PRIO_EN
    assign w_grant = s_axis_agg_tvalid;
`else
    // On a tie the input not served last wins; otherwise the only valid one.
    assign w_grant = (s_axis_byp_tvalid & s_axis_agg_tvalid) ? ~r_last_sel
                                                             : s_axis_agg_tvalid;
`endif

    always_comb begin
        m_axis_tdata      = s_axis_byp_tdata;
        m_axis_tkeep      = s_axis_byp_tkeep;
        m_axis_tuser      = s_axis_byp_tuser;
        m_axis_tlast      = s_axis_byp_tlast;
        m_axis_tvalid     = 1'b0;
        s_axis_byp_tready = 1'b0;
        s_axis_agg_tready = 1'b0;
        if (w_busy) begin
            if (r_sel) begin
                m_axis_tdata      = s_axis_agg_tdata;
                m_axis_tkeep      = s_axis_agg_tkeep;
                m_axis_tuser      = s_axis_agg_tuser;
                m_axis_tlast      = s_axis_agg_tlast;
                m_axis_tvalid     = s_axis_agg_tvalid;
                s_axis_agg_tready = m_axis_tready;
            end else begin
                m_axis_tvalid     = s_axis_byp_tvalid;
                s_axis_byp_tready = m_axis_tready;
            end
        end
    end

    assign w_eop = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            r_state    <= c_state_idle;
            r_sel      <= 1'b0;
            r_last_sel <= 1'b1;
        end else begin
            case (r_state)
                c_state_idle: begin
                    if (w_any_valid) begin
                        r_sel      <= w_grant;
                        r_last_sel <= w_grant;
                        r_state    <= c_state_busy;
                    end
                end
                c_state_busy: begin
                    if (w_eop) begin
                        r_state <= c_state_idle;
                    end
                end
                default: r_state <= c_state_idle;
            endcase
        end
    end

    // Clear takes precedence over a same-cycle increment.
    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            r_cnt_byp <= '0;
            r_cnt_agg <= '0;
        end else if (cnt_clear) begin
            r_cnt_byp <= '0;
            r_cnt_agg <= '0;
        end else if (w_eop) begin
            if (r_sel) begin
                r_cnt_agg <= r_cnt_agg + c_cnt_one;
            end else begin
                r_cnt_byp <= r_cnt_byp + c_cnt_one;
            end
        end
    end

    assign pkt_cnt_byp = r_cnt_byp;
    assign pkt_cnt_agg = r_cnt_agg;
    assign grant_busy  = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_agg_oq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_agg_oq_arbiter
// Description : Self-checking bench for agg_oq_arbiter (scoreboard + table).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_agg_oq_arbiter;

    localparam int DW = 32;
    localparam int UW = 16;
    localparam int KW = DW / 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          axis_resetn;
    logic [DW-1:0] s_axis_byp_tdata;
    logic [KW-1:0] s_axis_byp_tkeep;
    logic [UW-1:0] s_axis_byp_tuser;
    logic          s_axis_byp_tvalid;
    logic          s_axis_byp_tlast;
    logic          s_axis_byp_tready;
    logic [DW-1:0] s_axis_agg_tdata;
    logic [KW-1:0] s_axis_agg_tkeep;
    logic [UW-1:0] s_axis_agg_tuser;
    logic          s_axis_agg_tvalid;
    logic          s_axis_agg_tlast;
    logic          s_axis_agg_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          cnt_clear;
    logic [CW-1:0] pkt_cnt_byp;
    logic [CW-1:0] pkt_cnt_agg;
    logic          grant_busy;

    agg_oq_arbiter #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .CNT_WIDTH         (CW)
    ) dut (
        .axis_aclk        (clk),
        .axis_resetn      (axis_resetn),
        .s_axis_byp_tdata (s_axis_byp_tdata),
        .s_axis_byp_tkeep (s_axis_byp_tkeep),
        .s_axis_byp_tuser (s_axis_byp_tuser),
        .s_axis_byp_tvalid(s_axis_byp_tvalid),
        .s_axis_byp_tlast (s_axis_byp_tlast),
        .s_axis_byp_tready(s_axis_byp_tready),
        .s_axis_agg_tdata (s_axis_agg_tdata),
        .s_axis_agg_tkeep (s_axis_agg_tkeep),
        .s_axis_agg_tuser (s_axis_agg_tuser),
        .s_axis_agg_tvalid(s_axis_agg_tvalid),
        .s_axis_agg_tlast (s_axis_agg_tlast),
        .s_axis_agg_tready(s_axis_agg_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tready    (m_axis_tready),
        .cnt_clear        (cnt_clear),
        .pkt_cnt_byp      (pkt_cnt_byp),
        .pkt_cnt_agg      (pkt_cnt_agg),
        .grant_busy       (grant_busy)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          first;
        logic          src;
        int            gap;
    } beat_t;

    typedef struct {
        int nb;
        int na;
        int len;
        bit rnd;
        int exp_byp;
        int exp_agg;
    } vec_t;

    beat_t bq[$];
    beat_t aq[$];
    beat_t exp_q[$];
    int    bwait = 0;
    int    awt = 0;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    beats_seen = 0;
    int    stall_cycles = 0;
    int    first_cyc[2];
    int    last_cyc[2];
    bit    rnd_ready = 1'b0;
    vec_t  tbl[5];

    function automatic logic [KW-1:0] keep_of(input logic [DW-1:0] d);
        return d[3:0] | 4'b0001;
    endfunction

    function automatic logic [UW-1:0] user_of(input logic [DW-1:0] d);
        return d[31:16] ^ d[15:0];
    endfunction

    function automatic beat_t mk(input bit src, input int pkt, input int idx,
                                 input int len, input int gap);
        beat_t b;
        b.data  = {(src ? 4'hA : 4'hB), 12'(pkt), 16'(idx)};
        b.last  = (idx == len - 1);
        b.first = (idx == 0);
        b.src   = src;
        b.gap   = gap;
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_inputs();
        s_axis_byp_tvalid = (bq.size() > 0) && (bwait == 0);
        if (bq.size() > 0) begin
            s_axis_byp_tdata = bq[0].data;
            s_axis_byp_tkeep = keep_of(bq[0].data);
            s_axis_byp_tuser = user_of(bq[0].data);
            s_axis_byp_tlast = bq[0].last;
        end else begin
            s_axis_byp_tdata = '0;
            s_axis_byp_tkeep = '0;
            s_axis_byp_tuser = '0;
            s_axis_byp_tlast = 1'b0;
        end
        s_axis_agg_tvalid = (aq.size() > 0) && (awt == 0);
        if (aq.size() > 0) begin
            s_axis_agg_tdata = aq[0].data;
            s_axis_agg_tkeep = keep_of(aq[0].data);
            s_axis_agg_tuser = user_of(aq[0].data);
            s_axis_agg_tlast = aq[0].last;
        end else begin
            s_axis_agg_tdata = '0;
            s_axis_agg_tkeep = '0;
            s_axis_agg_tuser = '0;
            s_axis_agg_tlast = 1'b0;
        end
    endtask

    task automatic push_src(input bit src, input int pkt, input int len,
                            input int gap_idx, input int gap_len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b = mk(src, pkt, i, len, (i == gap_idx) ? gap_len : 0);
            if (src) begin
                if (aq.size() == 0) awt = b.gap;
                aq.push_back(b);
            end else begin
                if (bq.size() == 0) bwait = b.gap;
                bq.push_back(b);
            end
        end
        drive_inputs();
    endtask

    task automatic push_exp(input bit src, input int pkt, input int len);
        for (int i = 0; i < len; i++) exp_q.push_back(mk(src, pkt, i, len, 0));
    endtask

    task automatic check_beat();
        beat_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: actual data %0h required no beat", m_axis_tdata);
        end else begin
            e = exp_q.pop_front();
            chk("out_beat", 64'({m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata}),
                64'({e.last, user_of(e.data), keep_of(e.data), e.data}));
            if (e.first) first_cyc[e.src] = cyc;
            if (e.last)  last_cyc[e.src]  = cyc;
        end
        beats_seen++;
    endtask

    task automatic cycle();
        bit hb;
        bit ha;
        @(negedge clk);
        hb = s_axis_byp_tvalid && s_axis_byp_tready;
        ha = s_axis_agg_tvalid && s_axis_agg_tready;
        if (m_axis_tvalid && m_axis_tready) check_beat();
        if (grant_busy && !m_axis_tvalid) stall_cycles++;
        chk("tready_exclusive", 64'(s_axis_byp_tready & s_axis_agg_tready), 64'(0));
        @(posedge clk);
        #1;
        cyc++;
        if (hb) begin
            void'(bq.pop_front());
            bwait = (bq.size() > 0) ? bq[0].gap : 0;
        end else if (bwait > 0) begin
            bwait--;
        end
        if (ha) begin
            void'(aq.pop_front());
            awt = (aq.size() > 0) ? aq[0].gap : 0;
        end else if (awt > 0) begin
            awt--;
        end
        if (rnd_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
        drive_inputs();
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() > 0 || bq.size() > 0 || aq.size() > 0) && n < 3000) begin
            cycle();
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: outstanding beats %0d required 0", name, exp_q.size());
            exp_q.delete();
            bq.delete();
            aq.delete();
            drive_inputs();
        end
        cycle();
        chk({name, "_idle"}, 64'(grant_busy), 64'(0));
    endtask

    task automatic do_reset();
        axis_resetn = 1'b0;
        cnt_clear   = 1'b0;
        rnd_ready   = 1'b0;
        m_axis_tready = 1'b1;
        bq.delete();
        aq.delete();
        exp_q.delete();
        bwait = 0;
        awt   = 0;
        drive_inputs();
        cycle();
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_busy", 64'(grant_busy), 64'(0));
        chk("rst_treadys", 64'({s_axis_byp_tready, s_axis_agg_tready}), 64'(0));
        chk("rst_counters", 64'({pkt_cnt_byp, pkt_cnt_agg}), 64'(0));
        cycle();
        axis_resetn = 1'b1;
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        int rb, ra, pb, pa, len;
        bit last_g, g;

        tbl[0] = '{nb: 4,  na: 4, len: 2, rnd: 1'b0, exp_byp: 4, exp_agg: 4};
        tbl[1] = '{nb: 3,  na: 0, len: 1, rnd: 1'b1, exp_byp: 3, exp_agg: 0};
        tbl[2] = '{nb: 0,  na: 5, len: 3, rnd: 1'b1, exp_byp: 0, exp_agg: 5};
        tbl[3] = '{nb: 2,  na: 3, len: 1, rnd: 1'b1, exp_byp: 2, exp_agg: 3};
        tbl[4] = '{nb: 17, na: 2, len: 1, rnd: 1'b0, exp_byp: 1, exp_agg: 2};

        axis_resetn   = 1'b0;
        cnt_clear     = 1'b0;
        m_axis_tready = 1'b1;
        drive_inputs();

        // Single 3-beat bypass packet: one-cycle bubble, then contiguous beats.
        do_reset();
        push_src(1'b0, 0, 3, -1, 0);
        push_exp(1'b0, 0, 3);
        t0 = cyc;
        drain("t1");
        chk("t1_latency", 64'(first_cyc[0] - t0), 64'(1));
        chk("t1_contiguous", 64'(last_cyc[0] - first_cyc[0]), 64'(2));
        chk("t1_cnt_byp", 64'(pkt_cnt_byp), 64'(1));

        // Table of competing packet loads; expected order from a reference arbiter.
        for (int t = 0; t < 5; t++) begin
            do_reset();
            rnd_ready = tbl[t].rnd;
            len = tbl[t].len;
            for (int p = 0; p < tbl[t].nb; p++) push_src(1'b0, p, len, -1, 0);
            for (int p = 0; p < tbl[t].na; p++) push_src(1'b1, p, len, -1, 0);
            rb = tbl[t].nb; ra = tbl[t].na; pb = 0; pa = 0; last_g = 1'b1;
            while (rb > 0 || ra > 0) begin
`ifdef AGG_STRICT_PRIO_EN
                g = (ra > 0);
`else
                if (rb > 0 && ra > 0) g = ~last_g;
                else                  g = (ra > 0);
`endif
                last_g = g;
                if (g) begin push_exp(1'b1, pa, len); pa++; ra--; end
                else   begin push_exp(1'b0, pb, len); pb++; rb--; end
            end
            drain("tbl");
            rnd_ready = 1'b0;
            m_axis_tready = 1'b1;
            chk("tbl_cnt_byp", 64'(pkt_cnt_byp), 64'(tbl[t].exp_byp));
            chk("tbl_cnt_agg", 64'(pkt_cnt_agg), 64'(tbl[t].exp_agg));
        end

        // Agg granted, byp arrives mid-packet, downstream stalls five cycles.
        do_reset();
        push_src(1'b1, 0, 4, -1, 0);
        push_exp(1'b1, 0, 4);
        beats_seen = 0; n = 0;
        while (beats_seen < 1 && n < 20) begin cycle(); n++; end
        chk("t2_first_beat", 64'(beats_seen), 64'(1));
        push_src(1'b0, 0, 2, -1, 0);
        push_exp(1'b0, 0, 2);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t2_hold_valid", 64'(m_axis_tvalid), 64'(1));
            chk("t2_hold_data", 64'(m_axis_tdata), 64'(exp_q[0].data));
            chk("t2_byp_tready", 64'(s_axis_byp_tready), 64'(0));
        end
        m_axis_tready = 1'b1;
        drain("t2");
        chk("t2_bubble", 64'(first_cyc[0] - last_cyc[1]), 64'(2));

        // Granted input drops tvalid for four cycles mid-packet.
        do_reset();
        push_src(1'b1, 0, 3, 1, 4);
        push_exp(1'b1, 0, 3);
        stall_cycles = 0;
        drain("t3");
        chk("t3_stall_cycles", 64'(stall_cycles), 64'(4));
        chk("t3_cnt_agg", 64'(pkt_cnt_agg), 64'(1));

        // Counter wrap, then clear coinciding with a tlast handshake.
        do_reset();
        for (int p = 0; p < 15; p++) begin
            push_src(1'b1, p, 1, -1, 0);
            push_exp(1'b1, p, 1);
        end
        drain("t4a");
        chk("t4_cnt_max", 64'(pkt_cnt_agg), 64'(15));
        push_src(1'b1, 15, 1, -1, 0);
        push_exp(1'b1, 15, 1);
        drain("t4b");
        chk("t4_cnt_wrap", 64'(pkt_cnt_agg), 64'(0));
        push_src(1'b0, 0, 1, -1, 0);
        push_src(1'b1, 16, 1, -1, 0);
        push_exp(1'b0, 0, 1);
        push_exp(1'b1, 16, 1);
        drain("t4c");
        chk("t4_cnt_pair", 64'({pkt_cnt_byp, pkt_cnt_agg}), 64'({4'd1, 4'd1}));
        push_src(1'b1, 20, 1, -1, 0);
        push_exp(1'b1, 20, 1);
        m_axis_tready = 1'b0;
        n = 0;
        while (!m_axis_tvalid && n < 20) begin cycle(); n++; end
        chk("t4_valid_seen", 64'(m_axis_tvalid), 64'(1));
        cnt_clear = 1'b1;
        m_axis_tready = 1'b1;
        cycle();
        cnt_clear = 1'b0;
        chk("t4_clear_agg", 64'(pkt_cnt_agg), 64'(0));
        chk("t4_clear_byp", 64'(pkt_cnt_byp), 64'(0));
        drain("t4d");

        // Reset during beat 2 of a 4-beat packet.
        do_reset();
        push_src(1'b0, 0, 1, -1, 0);
        push_exp(1'b0, 0, 1);
        drain("t5a");
        chk("t5_cnt_pre", 64'(pkt_cnt_byp), 64'(1));
        push_src(1'b0, 1, 4, -1, 0);
        push_exp(1'b0, 1, 4);
        beats_seen = 0; n = 0;
        while (beats_seen < 1 && n < 20) begin cycle(); n++; end
        axis_resetn = 1'b0;
        cycle();
        chk("t5_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("t5_treadys", 64'({s_axis_byp_tready, s_axis_agg_tready}), 64'(0));
        chk("t5_counters", 64'({pkt_cnt_byp, pkt_cnt_agg}), 64'(0));
        chk("t5_busy", 64'(grant_busy), 64'(0));
        bq.delete();
        aq.delete();
        exp_q.delete();
        bwait = 0;
        awt = 0;
        drive_inputs();
        axis_resetn = 1'b1;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
